term_host: RTL and testbench

- Host-side initiator for the terminal character buffer byte interface.
- Converts high-level requests (cursor move, screen refresh) into single-byte command strobes. Collects the returned byte stream.
- Keeps a shadow copy of the screen and a local cursor pointer.
- Sits between the control logic / user input path and the terminal buffer. Owns one command and one response channel.

---
 rtl/term_host_if.sv | 33 +++
 rtl/term_host.sv | 206 ++++++++++++++++++++
 tb/tb_term_host.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/term_host_if.sv
`default_nettype none
// ============================================================================
// Module      : term_host_if
// Description : Request, command and response channels between the term_host
//               initiator and its environment (control logic plus terminal
//               buffer). The master view belongs to term_host and the slave
//               view to whatever drives requests and returns bytes.
// Revision    : 1.0 - initial release
// ============================================================================
interface term_host_if;
    logic [2:0] req_op;
    logic       req_v;
    logic       req_ready;
    logic [7:0] o_cmd;
    logic       o_cmd_v;
    logic [7:0] i_data;
    logic       i_data_v;
    logic [7:0] rsp_char;
    logic       rsp_v;
    logic       frame_done;
    logic       err;

    modport master (
        input  req_op, req_v, i_data, i_data_v,
        output req_ready, o_cmd, o_cmd_v, rsp_char, rsp_v, frame_done, err
    );

    modport slave (
        output req_op, req_v, i_data, i_data_v,
        input  req_ready, o_cmd, o_cmd_v, rsp_char, rsp_v, frame_done, err
    );
endinterface
`default_nettype wire

// File: rtl/term_host.sv
`default_nettype none
// ============================================================================
// Module      : term_host
// Description : Host-side initiator for the terminal character buffer. Turns
//               cursor-move and refresh requests into single command bytes,
//               collects the returned byte stream, keeps a local cursor and a
//               shadow copy of the screen, and aborts on response timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module term_host #(
    parameter int COLS         = 40,
    parameter int SCREEN_BYTES = 1024,
    parameter int AW           = 10,
    parameter int TIMEOUT      = 255
) (
    input  wire logic          clk,
    input  wire logic          rst,
    term_host_if.master        bus,
    output logic [AW-1:0]      cursor,
    input  wire logic [AW-1:0] rd_addr,
    output logic [7:0]         rd_data,
    output logic [7:0]         stray_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [AW-1:0] c_cols     = AW'(COLS);
    localparam logic [AW-1:0] c_one      = AW'(1);
    localparam logic [AW-1:0] c_last_idx = AW'(SCREEN_BYTES - 1);
    localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT - 1);
    localparam logic [2:0]    c_op_ref   = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_SEND       = 2'd1,
        S_WAIT_CHAR  = 2'd2,
        S_WAIT_FRAME = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_refresh;
    logic [AW-1:0]   r_idx;
    logic [TW-1:0]   r_timer;
    logic [7:0]      r_mem [SCREEN_BYTES];

    logic            w_accept;
    logic            w_op_ok;
    logic            w_start;
    logic            w_char_done;
    logic            w_frame_last;
    logic            w_we;
    logic            w_timeout;
    logic            w_err_set;
    logic            w_in_wait;
    logic [7:0]      w_cmd_byte;
    logic [AW-1:0]   w_cursor_nxt;

    assign w_accept  = bus.req_v && (r_state == S_IDLE);
    assign w_op_ok   = (bus.req_op <= c_op_ref);
    assign w_start   = w_accept && w_op_ok;
    assign w_in_wait = (r_state == S_WAIT_CHAR) || (r_state == S_WAIT_FRAME);
    assign w_err_set = (w_accept && !w_op_ok) || w_timeout;

    assign bus.req_ready = (r_state == S_IDLE);

    // Command byte and cursor target for the request being accepted.
    always_comb begin
        w_cmd_byte   = 8'h00;
        w_cursor_nxt = cursor;
        case (bus.req_op)
            3'd0: begin w_cmd_byte = 8'h6A; w_cursor_nxt = cursor + c_cols; end
            3'd1: begin w_cmd_byte = 8'h6B; w_cursor_nxt = cursor - c_cols; end
            3'd2: begin w_cmd_byte = 8'h68; w_cursor_nxt = cursor - c_one;  end
            3'd3: begin w_cmd_byte = 8'h6C; w_cursor_nxt = cursor + c_one;  end
            3'd4: begin w_cmd_byte = 8'h20; end
            default: begin w_cmd_byte = 8'h00; end
        endcase
    end

    // Next-state logic; data arriving in the timeout cycle wins over the timeout.
    always_comb begin
        w_state_nxt  = r_state;
        w_char_done  = 1'b0;
        w_frame_last = 1'b0;
        w_we         = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                w_state_nxt = r_refresh ? S_WAIT_FRAME : S_WAIT_CHAR;
            end
            S_WAIT_CHAR: begin
                if (bus.i_data_v) begin
                    w_char_done = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_timer == c_tmo_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_FRAME: begin
                if (bus.i_data_v) begin
                    w_we = 1'b1;
                    if (r_idx == c_last_idx) begin
                        w_frame_last = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end
                end else if (r_timer == c_tmo_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request latch, command strobe and local cursor; cursor moves as the command goes out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh   <= 1'b0;
            bus.o_cmd   <= 8'h00;
            bus.o_cmd_v <= 1'b0;
            cursor      <= '0;
        end else begin
            bus.o_cmd_v <= w_start;
            if (w_start) begin
                r_refresh <= (bus.req_op == c_op_ref);
                bus.o_cmd <= w_cmd_byte;
                cursor    <= w_cursor_nxt;
            end
        end
    end

    // Response timer and frame byte index; both restart as a wait state is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
            r_idx   <= '0;
        end else begin
            if (r_state == S_SEND || bus.i_data_v) begin
                r_timer <= '0;
            end else if (w_in_wait) begin
                r_timer <= r_timer + TW'(1);
            end
            if (r_state == S_SEND) begin
                r_idx <= '0;
            end else if (w_we) begin
                r_idx <= r_idx + c_one;
            end
        end
    end

    // Registered result pulses and the returned move character.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_char   <= 8'h00;
            bus.rsp_v      <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            bus.rsp_v      <= w_char_done;
            bus.frame_done <= w_frame_last;
            bus.err        <= w_err_set;
            if (w_char_done) begin
                bus.rsp_char <= bus.i_data;
            end
        end
    end

    // Saturating count of bytes that arrive when no response is outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            stray_cnt <= 8'h00;
        end else if (bus.i_data_v && (r_state == S_IDLE || r_state == S_SEND)
                     && stray_cnt != 8'hFF) begin
            stray_cnt <= stray_cnt + 8'h01;
        end
    end

    // Shadow screen: capture write port and registered read port (old data on collision).
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_idx] <= bus.i_data;
        end
        rd_data <= r_mem[rd_addr];
    end

endmodule
`default_nettype wire

// File: tb/tb_term_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_term_host
// Description : Self-checking bench for term_host. Stimulus pushes expected
//               command bytes, characters and pulses into a scoreboard that a
//               negedge monitor drains; a cursor/shadow/stray model is kept
//               with plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_term_host;
    localparam int COLS = 40;
    localparam int SB   = 1024;
    localparam int AW   = 10;
    localparam int TMO  = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] cursor;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [7:0]    stray_cnt;

    term_host_if bus();

    term_host #(.COLS(COLS), .SCREEN_BYTES(SB), .AW(AW), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .cursor    (cursor),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .stray_cnt (stray_cnt)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] q_cmd[$];
    logic [7:0] q_rsp[$];
    int         exp_frames = 0;
    int         exp_errs   = 0;
    int         m_cursor   = 0;
    int         m_stray    = 0;
    logic [7:0] m_shadow [SB];
    logic [7:0] cmd_tab [5];
    int         step_tab [4];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every output event must match an outstanding expectation.
    always @(negedge clk) begin
        if (bus.o_cmd_v === 1'b1) begin
            if (q_cmd.size() == 0) check("unexpected_cmd", int'(bus.o_cmd), -1);
            else                   check("cmd_byte", int'(bus.o_cmd), int'(q_cmd.pop_front()));
        end
        if (bus.rsp_v === 1'b1) begin
            if (q_rsp.size() == 0) check("unexpected_rsp", int'(bus.rsp_char), -1);
            else                   check("rsp_char", int'(bus.rsp_char), int'(q_rsp.pop_front()));
        end
        if (bus.frame_done === 1'b1) begin
            check("frame_done_expected", int'(exp_frames > 0), 1);
            if (exp_frames > 0) exp_frames--;
        end
        if (bus.err === 1'b1) begin
            check("err_expected", int'(exp_errs > 0), 1);
            if (exp_errs > 0) exp_errs--;
        end
    end

    function automatic int wrap(input int v);
        return ((v % SB) + SB) % SB;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.req_v = 1'b0;
        bus.i_data_v = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_cursor = 0;
        m_stray = 0;
        @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] op);
        bus.req_op = op;
        bus.req_v  = 1'b1;
        @(negedge clk);
        bus.req_v  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        bus.i_data   = d;
        bus.i_data_v = 1'b1;
        @(negedge clk);
        bus.i_data_v = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int cnt = 0;
        while (bus.req_ready !== 1'b1 && cnt < limit) begin
            @(negedge clk);
            cnt++;
        end
        if (bus.req_ready !== 1'b1) check("wait_idle_timeout", cnt, -1);
    endtask

    task automatic do_move(input int op, input logic [7:0] d, input int gap, input bit poke);
        q_cmd.push_back(cmd_tab[op]);
        q_rsp.push_back(d);
        m_cursor = wrap(m_cursor + step_tab[op]);
        issue(3'(op));
        @(negedge clk);
        if (poke) begin
            bus.req_op = 3'd4;
            bus.req_v  = 1'b1;
            @(negedge clk);
            bus.req_v  = 1'b0;
        end
        repeat (gap) @(negedge clk);
        send_byte(d);
        wait_idle(50);
        check("cursor_after_move", int'(cursor), m_cursor);
    endtask

    // Refresh streaming nbytes; stop_mode 0 = normal end, 1 = go silent, 2 = reset.
    task automatic do_refresh(input int nbytes, input bit rnd, input int stop_mode);
        logic [7:0] d;
        q_cmd.push_back(cmd_tab[4]);
        if (nbytes == SB) exp_frames++;
        issue(3'd4);
        @(negedge clk);
        for (int i = 0; i < nbytes; i++) begin
            d = rnd ? 8'($urandom) : 8'(i);
            m_shadow[i] = d;
            repeat ($urandom_range(0, 4)) @(negedge clk);
            send_byte(d);
        end
        if (stop_mode == 1) begin
            exp_errs++;
            wait_idle(TMO + 20);
        end else if (stop_mode == 2) begin
            do_reset();
        end else begin
            wait_idle(50);
        end
    endtask

    task automatic read_check(input int addr);
        rd_addr = AW'(addr);
        @(negedge clk);
        @(negedge clk);
        check("rd_data", int'(rd_data), int'(m_shadow[addr]));
    endtask

    initial begin
        int cnt;
        int op;
        cmd_tab  = '{8'h6A, 8'h6B, 8'h68, 8'h6C, 8'h20};
        step_tab = '{COLS, -COLS, -1, 1};
        bus.req_op = 3'd0;
        bus.i_data = 8'h00;
        rd_addr    = '0;
        do_reset();

        check("reset_req_ready", int'(bus.req_ready), 1);
        check("reset_cursor", int'(cursor), 0);
        check("reset_stray", int'(stray_cnt), 0);
        check("reset_rsp_char", int'(bus.rsp_char), 0);
        check("reset_o_cmd", int'(bus.o_cmd), 0);
        check("reset_o_cmd_v", int'(bus.o_cmd_v), 0);

        do_move(3, 8'h41, 2, 1'b0);
        check("right_cursor", int'(cursor), 1);
        check("ready_after_move", int'(bus.req_ready), 1);

        do_reset();
        do_move(1, 8'h55, 0, 1'b0);
        check("up_from_0", int'(cursor), 984);
        do_reset();
        do_move(2, 8'h7E, 1, 1'b0);
        check("left_from_0", int'(cursor), 1023);

        do_move(0, 8'h10, 3, 1'b1);

        for (int k = 0; k < 30; k++) begin
            op = $urandom_range(0, 7);
            if (op <= 3) begin
                do_move(op, 8'($urandom), $urandom_range(0, 10), 1'b0);
            end else if (op >= 5) begin
                exp_errs++;
                issue(3'(op));
                @(negedge clk);
                check("invalid_ready", int'(bus.req_ready), 1);
            end
        end

        do_refresh(SB, 1'b0, 0);
        read_check(5);
        read_check(1023);
        for (int k = 0; k < 6; k++) read_check($urandom_range(0, SB - 1));

        q_cmd.push_back(cmd_tab[3]);
        m_cursor = wrap(m_cursor + 1);
        exp_errs++;
        issue(3'd3);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (bus.err !== 1'b1 && cnt < TMO + 20);
        check("timeout_latency", cnt - 1, TMO);
        wait_idle(10);
        check("cursor_kept_after_timeout", int'(cursor), m_cursor);
        do_move(2, 8'h33, 4, 1'b0);

        exp_errs++;
        issue(3'd6);
        repeat (3) @(negedge clk);
        check("invalid_op_ready", int'(bus.req_ready), 1);

        for (int k = 0; k < 3; k++) send_byte(8'hAA);
        m_stray += 3;
        check("stray_3", int'(stray_cnt), m_stray);
        bus.i_data_v = 1'b1;
        repeat (300) @(negedge clk);
        bus.i_data_v = 1'b0;
        m_stray = (m_stray + 300 > 255) ? 255 : m_stray + 300;
        check("stray_sat", int'(stray_cnt), m_stray);

        do_refresh(10, 1'b1, 1);
        read_check(3);
        read_check(500);

        do_refresh(500, 1'b1, 2);
        check("midreset_ready", int'(bus.req_ready), 1);
        check("midreset_cursor", int'(cursor), 0);
        check("midreset_stray", int'(stray_cnt), 0);
        do_refresh(SB, 1'b1, 0);
        read_check(0);
        read_check(777);
        read_check(1023);

        repeat (5) @(negedge clk);
        check("cmd_queue_drained", q_cmd.size(), 0);
        check("rsp_queue_drained", q_rsp.size(), 0);
        check("frames_drained", exp_frames, 0);
        check("errs_drained", exp_errs, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
